// File: rtl/byte_word_assembler_if.sv
// Byte-in / word-out handshake bundle for the byte-to-word assembler.
// The slave side is the assembler; the master side feeds bytes and consumes words.
interface byte_word_assembler_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [2:0]  out_count;

    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_count
    );

    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_word, out_count
    );
endinterface

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into 32-bit words with selectable lane order, last-flag
// flush of partial words and a one-word stall buffer under output backpressure.
module byte_word_assembler #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_word_assembler_if.slave bus,
    output logic [CNT_W-1:0]     word_count
);

    typedef enum logic {FILL, STALL} state_t;

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        vld_p1;
    logic [31:0] word_p1;
    logic [2:0]  count_p1;
    logic        slot_free;
    logic        accept;
    logic        done;
    logic [31:0] merged;
    logic        load;
    logic [31:0] load_word;
    logic [2:0]  load_count;

    function automatic logic [31:0] place_lane(input logic [7:0] b, input logic [1:0] i);
        int lo;
        lo = MSB_FIRST ? (24 - 8 * int'(i)) : (8 * int'(i));
        return {24'd0, b} << lo;
    endfunction

    assign slot_free  = !vld_p1 || bus.out_ready;
    assign accept     = bus.in_valid && (state == FILL);
    assign done       = accept && ((idx == 2'd3) || bus.in_last);
    assign merged     = acc | place_lane(bus.in_byte, idx);
    // idx is left at the completing byte's index while stalled, so count follows it
    assign load_count = {1'b0, idx} + 3'd1;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        load      = 1'b0;
        load_word = acc;
        unique case (state)
            FILL: begin
                if (accept) begin
                    if (done) begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_word = merged;
                            acc_nxt   = 32'd0;
                            idx_nxt   = 2'd0;
                        end else begin
                            acc_nxt   = merged;
                            state_nxt = STALL;
                        end
                    end else begin
                        acc_nxt = merged;
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            STALL: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = acc;
                    acc_nxt   = 32'd0;
                    idx_nxt   = 2'd0;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            acc        <= 32'd0;
            idx        <= 2'd0;
            vld_p1     <= 1'b0;
            word_p1    <= 32'd0;
            count_p1   <= 3'd0;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            if (load) begin
                vld_p1   <= 1'b1;
                word_p1  <= load_word;
                count_p1 <= load_count;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (vld_p1 && bus.out_ready)
                word_count <= word_count + 1'b1;
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = vld_p1;
    assign bus.out_word  = word_p1;
    assign bus.out_count = count_p1;

endmodule
